sha256_padder: RTL and testbench
================================

Name: sha256_padder

Overview:
- Upstream message-formatting stage for the SHA-256 hasher core.
- Accepts a big-endian 32-bit word stream of arbitrary byte length and performs FIPS 180-4 padding: appends the 0x80 byte, zero fill and the 64-bit bit-length.
- Emits 512-bit blocks as sixteen 32-bit words with block/message framing for the compression core.

Parameters:
- LEN_W, 64: width of the internal bit-length counter, range 32..64. Length words are zero-extended to 64 bits.
- BLOCK_WORDS, 16: words per block. Fixed; only present for readability.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  reset; synchronous, active-high.
- s_data  in  32  message word; byte 0 in [31:24].
- s_bytes  in  3  valid bytes on the s_last beat, 1..4. The value 0 is legal only with s_last and means an empty message. Ignored when s_last=0.
- s_last  in  1  final beat of the message.
- s_valid  in  1  input word valid.
- s_ready  out  1  input word accepted when s_valid and s_ready are both high.
- m_data  out  32  padded block word.
- m_first  out  1  word index 0 of a block.
- m_block_end  out  1  word index 15 of a block.
- m_msg_end  out  1  word 15 of the final block of a message.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accept.

Behaviour:
- Reset values (ARESET sampled at ACLK): m_valid=0, m_data=0, m_first=0, m_block_end=0, m_msg_end=0, state=DATA, word index=0, length counter=0. s_ready=0 while ARESET=1.
- Output register: m_data and flags are registered. Load happens when !m_valid or m_ready ("advance"). Input-to-output latency is 1 cycle; throughput is 1 word per cycle.
- Output hold: m_data and flags are held stable while m_valid && !m_ready.
- Word index: a 4-bit idx increments on every output load and wraps 15 to 0. m_first = (idx==0); m_block_end = (idx==15).
- Length counter: adds 8 × (accepted bytes) per accepted beat; full beats add 32. Wraps modulo 2^LEN_W.
- FSM states: DATA, PAD80, ZERO, LEN_HI, LEN_LO.
- DATA:
  - s_ready = advance.
  - Non-last beat: output s_data unchanged.
  - Last beat with n = s_bytes in 1..3: output s_data with bytes ≥ n cleared and byte n = 0x80.
  - Last beat with n = 0: output 0x80000000.
  - In each of the three cases above, next state = LEN_HI if the emitted idx==13, otherwise ZERO.
  - Last beat with n = 4: output s_data, next state = PAD80.
- PAD80: s_ready=0. Output 0x80000000; next state is LEN_HI if emitted idx==13, otherwise ZERO.
- ZERO: output 0x00000000 until the emitted idx==13, then go to LEN_HI.
  - If the pad byte landed in idx 14 or 15, the zero fill runs through the end of that block and then words 0..13 of an extra block.
- LEN_HI: output bits [63:32] of the zero-extended length.
- LEN_LO: output bits [31:0], assert m_msg_end, clear the length counter, return to DATA.
- States PAD80 through LEN_LO advance only on advance.
- A new message is accepted in the cycle after LEN_LO loads; no bubble is required.
- Reset mid-message: all state is discarded; the partially emitted block is never completed.
- Overflow: length beyond 2^LEN_W bits wraps silently. No error port.

Optional Feature:
- Macro: SHA256_PADDER_BYTE_SWAP_EN.
- Defined: s_data is byte-reversed before use, i.e. the little-endian AXI word from the PS: byte 0 in [7:0]. s_bytes then counts from [7:0] upward. Output is unchanged, still big-endian.
- Undefined: s_data is taken as big-endian with no swap logic.

Decomposition:
- Package sha256_pkg:
  - state enum sha256_pad_state_t.
  - BLOCK_WORDS=16, LEN_HI_IDX=14, PAD_WORD=32'h80000000.
  - word typedef sha256_word_t (logic [31:0]).
- Sub-module sha256_pad_mask (combinational): inputs data and n; returns the masked word with the 0x80 insertion. Reused by the DATA last-beat path.

Test Plan:
- "abc": one beat 0x61626300, s_bytes=3, s_last → 0x61626380, then 13 × 0x0, then 0x00000000, 0x00000018; m_msg_end on word 15.
- Empty: one beat with s_bytes=0, s_last → 0x80000000, 13 zeros, length 0/0. Output matches the known empty-string SHA-256 block.
- 55 bytes: 13 full beats + 1 beat with s_bytes=3 → single block; word 13 ends in 0x80; words 14–15 = 0x00000000, 0x000001B8.
- 56 bytes: 14 full beats → word14=0x80000000, word15=0; second block has 14 zeros then 0x00000000, 0x000001C0. m_msg_end only on the second block's word 15.
- Backpressure: m_ready low for 3 cycles at idx 5 → m_data and idx held, s_ready=0, no word lost or duplicated. Also random m_ready at 50% over 3 back-to-back messages → sequences identical to the no-stall run.
- Reset mid-padding: ARESET for 1 cycle while in ZERO → next cycle m_valid=0 and idx=0. A following "abc" message yields exactly the block from the first scenario.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message padder.
package sha256_pkg;

    localparam int BLOCK_WORDS = 16;
    localparam int LEN_HI_IDX  = 14;

    typedef logic [31:0] sha256_word_t;

    localparam sha256_word_t PAD_WORD = 32'h8000_0000;

    typedef enum logic [2:0] {
        ST_DATA,
        ST_PAD80,
        ST_ZERO,
        ST_LEN_HI,
        ST_LEN_LO
    } sha256_pad_state_t;

    function automatic sha256_word_t byte_swap(input sha256_word_t w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/sha256_pad_mask.sv
// Final-beat formatter: keeps the first n message bytes, writes 0x80 into byte n
// and clears the rest. n >= 4 passes the word through untouched.
module sha256_pad_mask
    import sha256_pkg::*;
(
    input  sha256_word_t data,
    input  logic [2:0]   n,
    output sha256_word_t masked
);

    always_comb begin
        masked = data;
        case (n)
            3'd0:    masked = PAD_WORD;
            3'd1:    masked = {data[31:24], 8'h80, 16'h0000};
            3'd2:    masked = {data[31:16], 8'h80, 8'h00};
            3'd3:    masked = {data[31:8], 8'h80};
            default: masked = data;
        endcase
    end

endmodule

// File: rtl/sha256_padder.sv
// FIPS 180-4 padder: big-endian 32-bit word stream in, 16-word padded blocks out.
// Define SHA256_PADDER_BYTE_SWAP_EN to accept little-endian input words.
//
// state     | meaning
// ST_DATA   | passing message words; last beat may carry the 0x80 byte
// ST_PAD80  | message ended word-aligned; emit the 0x80000000 word
// ST_ZERO   | zero fill up to word 13 of the (possibly extra) block
// ST_LEN_HI | emit bit length [63:32]
// ST_LEN_LO | emit bit length [31:0], end of message
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W       = 64,
    parameter int BLOCK_WORDS = 16
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic [31:0] s_data,
    input  logic [2:0]  s_bytes,
    input  logic        s_last,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [31:0] m_data,
    output logic        m_first,
    output logic        m_block_end,
    output logic        m_msg_end,
    output logic        m_valid,
    input  logic        m_ready
);

    localparam logic [3:0] IDX_LAST     = 4'(BLOCK_WORDS - 1);
    localparam logic [3:0] IDX_PRE_LEN  = 4'(LEN_HI_IDX - 1);

    sha256_pad_state_t state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic [LEN_W-1:0]  len_q, len_d;
    sha256_word_t      m_data_q, m_data_d;
    logic              m_valid_q, m_valid_d;
    logic              m_first_q, m_first_d;
    logic              m_block_end_q, m_block_end_d;
    logic              m_msg_end_q, m_msg_end_d;

    sha256_word_t      din;
    sha256_word_t      masked;
    sha256_word_t      word;
    logic [63:0]       len64;
    logic [5:0]        add_bits;
    logic              advance;
    logic              load;
    logic              msg_end;
    logic              n_full;

`ifdef SHA256_PADDER_BYTE_SWAP_EN
    assign din = byte_swap(s_data);
`else
    assign din = s_data;
`endif

    sha256_pad_mask u_mask (
        .data   (din),
        .n      (s_bytes),
        .masked (masked)
    );

    assign advance = !m_valid_q || m_ready;
    assign s_ready = !ARESET && (state_q == ST_DATA) && advance;
    assign len64   = 64'(len_q);
    assign n_full  = (s_bytes >= 3'd4);

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        len_d         = len_q;
        m_data_d      = m_data_q;
        m_valid_d     = m_valid_q;
        m_first_d     = m_first_q;
        m_block_end_d = m_block_end_q;
        m_msg_end_d   = m_msg_end_q;
        load          = 1'b0;
        word          = '0;
        msg_end       = 1'b0;
        add_bits      = 6'd32;

        if (!s_last || n_full) begin
            add_bits = 6'd32;
        end else begin
            add_bits = {s_bytes, 3'b000};
        end

        if (advance) begin
            case (state_q)
                ST_DATA: begin
                    if (s_valid) begin
                        load  = 1'b1;
                        len_d = len_q + LEN_W'(add_bits);
                        if (!s_last) begin
                            word = din;
                        end else if (n_full) begin
                            word    = din;
                            state_d = ST_PAD80;
                        end else begin
                            word    = masked;
                            state_d = (idx_q == IDX_PRE_LEN) ? ST_LEN_HI : ST_ZERO;
                        end
                    end
                end
                ST_PAD80: begin
                    load    = 1'b1;
                    word    = PAD_WORD;
                    state_d = (idx_q == IDX_PRE_LEN) ? ST_LEN_HI : ST_ZERO;
                end
                ST_ZERO: begin
                    load = 1'b1;
                    word = '0;
                    if (idx_q == IDX_PRE_LEN) begin
                        state_d = ST_LEN_HI;
                    end
                end
                ST_LEN_HI: begin
                    load    = 1'b1;
                    word    = len64[63:32];
                    state_d = ST_LEN_LO;
                end
                ST_LEN_LO: begin
                    load    = 1'b1;
                    word    = len64[31:0];
                    msg_end = 1'b1;
                    len_d   = '0;
                    state_d = ST_DATA;
                end
                default: state_d = ST_DATA;
            endcase

            // An idle DATA cycle drains the output register instead of loading it.
            m_valid_d = load;
            if (load) begin
                m_data_d      = word;
                m_first_d     = (idx_q == 4'd0);
                m_block_end_d = (idx_q == IDX_LAST);
                m_msg_end_d   = msg_end;
                idx_d         = idx_q + 4'd1;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q       <= ST_DATA;
            idx_q         <= '0;
            len_q         <= '0;
            m_data_q      <= '0;
            m_valid_q     <= 1'b0;
            m_first_q     <= 1'b0;
            m_block_end_q <= 1'b0;
            m_msg_end_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            len_q         <= len_d;
            m_data_q      <= m_data_d;
            m_valid_q     <= m_valid_d;
            m_first_q     <= m_first_d;
            m_block_end_q <= m_block_end_d;
            m_msg_end_q   <= m_msg_end_d;
        end
    end

    assign m_data      = m_data_q;
    assign m_valid     = m_valid_q;
    assign m_first     = m_first_q;
    assign m_block_end = m_block_end_q;
    assign m_msg_end   = m_msg_end_q;

endmodule

// File: tb/tb_sha256_padder.sv
// Self-checking bench for sha256_padder: byte-level padding model, scoreboard
// compare on every output handshake, hold/backpressure checks and reset scenarios.
module tb_sha256_padder;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [31:0] s_data;
    logic [2:0]  s_bytes;
    logic        s_last;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] m_data;
    logic        m_first;
    logic        m_block_end;
    logic        m_msg_end;
    logic        m_valid;
    logic        m_ready;

    sha256_padder dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .s_data      (s_data),
        .s_bytes     (s_bytes),
        .s_last      (s_last),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .m_data      (m_data),
        .m_first     (m_first),
        .m_block_end (m_block_end),
        .m_msg_end   (m_msg_end),
        .m_valid     (m_valid),
        .m_ready     (m_ready)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed {
        logic [31:0] d;
        logic        f;
        logic        be;
        logic        me;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    int          hs_count = 0;
    int          rdy_mode = 0;
    int          stall_left = 0;
    logic [7:0]  msg[$];
    exp_t        mdl[$];
    exp_t        exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Padding model: work on the byte stream, then slice into words.
    task automatic build_model();
        logic [7:0]  p[$];
        logic [63:0] bits;
        int          nw;
        exp_t        e;
        p = msg;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        bits = 64'(msg.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
        nw = p.size() / 4;
        mdl.delete();
        for (int w = 0; w < nw; w++) begin
            e.d  = {p[4*w], p[4*w+1], p[4*w+2], p[4*w+3]};
            e.f  = ((w % 16) == 0);
            e.be = ((w % 16) == 15);
            e.me = (w == nw - 1);
            mdl.push_back(e);
        end
    endtask

    task automatic expect_msg();
        build_model();
        foreach (mdl[i]) exp_q.push_back(mdl[i]);
    endtask

    task automatic rand_msg(input int len);
        msg.delete();
        for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
    endtask

    task automatic send_msg(input bit gaps);
        int         len;
        int         nb;
        int         cnt;
        int         guard;
        logic       took;
        logic [7:0] b[4];
        logic [31:0] w;
        len = msg.size();
        nb  = (len == 0) ? 1 : (len + 3) / 4;
        for (int bt = 0; bt < nb; bt++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                repeat ($urandom_range(1, 3)) begin @(posedge ACLK); #1; end
            end
            cnt = len - 4 * bt;
            if (cnt > 4) cnt = 4;
            for (int k = 0; k < 4; k++) b[k] = (k < cnt) ? msg[4*bt + k] : 8'($urandom);
            w = {b[0], b[1], b[2], b[3]};
`ifdef SHA256_PADDER_BYTE_SWAP_EN
            s_data = {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
            s_data = w;
`endif
            s_last  = (bt == nb - 1);
            s_bytes = (bt == nb - 1) ? 3'(cnt) : 3'($urandom);
            s_valid = 1'b1;
            guard = 0;
            forever begin
                @(negedge ACLK);
                took = s_ready;
                @(posedge ACLK);
                #1;
                if (took) break;
                guard++;
                if (guard > 1000) begin
                    errors++;
                    checks++;
                    $display("FAIL send_timeout: beat %0d not accepted, s_ready stuck %0b expected 1", bt, s_ready);
                    s_valid = 1'b0;
                    return;
                end
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 3000) begin
            @(posedge ACLK);
            #1;
            guard++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d words outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) begin @(posedge ACLK); #1; end
    endtask

    // Downstream ready generator.
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge ACLK);
            #1;
            case (rdy_mode)
                1: m_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (stall_left > 0 && m_valid && (hs_count % 16) == 5) begin
                        m_ready = 1'b0;
                        stall_left--;
                    end else begin
                        m_ready = 1'b1;
                    end
                end
                default: m_ready = 1'b1;
            endcase
        end
    end

    // Scoreboard and stability monitor, sampled mid-cycle.
    logic        hold_v = 1'b0;
    logic [34:0] hold_w;
    exp_t        e_mon;

    always @(negedge ACLK) begin
        if (ARESET) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_valid", 64'(m_valid), 64'd1);
                chk("hold_word", 64'({m_data, m_first, m_block_end, m_msg_end}), 64'(hold_w));
            end
            if (m_valid && !m_ready) begin
                chk("s_ready_stalled", 64'(s_ready), 64'd0);
                hold_v = 1'b1;
                hold_w = {m_data, m_first, m_block_end, m_msg_end};
            end else begin
                hold_v = 1'b0;
            end
            if (m_valid && m_ready) begin
                hs_count++;
                if (exp_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_word: got %0h with no word expected", m_data);
                end else begin
                    e_mon = exp_q.pop_front();
                    chk("m_data", 64'(m_data), 64'(e_mon.d));
                    chk("m_flags", 64'({m_first, m_block_end, m_msg_end}),
                        64'({e_mon.f, e_mon.be, e_mon.me}));
                end
            end
        end
    end

    initial begin
        int guard;
        ARESET  = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_bytes = 3'd0;
        s_data  = 32'h0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_flags", 64'({m_first, m_block_end, m_msg_end}), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        @(negedge ACLK);
        chk("idle_s_ready", 64'(s_ready), 64'd1);
        @(posedge ACLK);
        #1;

        // "abc"
        msg.delete();
        msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
        build_model();
        chk("mdl_abc_size", 64'(mdl.size()), 64'd16);
        chk("mdl_abc_w0", 64'(mdl[0].d), 64'h61626380);
        chk("mdl_abc_w15", 64'(mdl[15].d), 64'h18);
        expect_msg();
        send_msg(1'b0);
        wait_drain();

        // empty message
        msg.delete();
        build_model();
        chk("mdl_empty_w0", 64'(mdl[0].d), 64'h80000000);
        chk("mdl_empty_w15", 64'(mdl[15].d), 64'h0);
        expect_msg();
        send_msg(1'b0);
        wait_drain();

        // 55 bytes: single block
        rand_msg(55);
        build_model();
        chk("mdl_55_size", 64'(mdl.size()), 64'd16);
        chk("mdl_55_w13_pad", 64'(mdl[13].d[7:0]), 64'h80);
        chk("mdl_55_w15", 64'(mdl[15].d), 64'h1B8);
        expect_msg();
        send_msg(1'b0);
        wait_drain();

        // 56 bytes: spills into a second block
        rand_msg(56);
        build_model();
        chk("mdl_56_size", 64'(mdl.size()), 64'd32);
        chk("mdl_56_w14", 64'(mdl[14].d), 64'h80000000);
        chk("mdl_56_w15_end", 64'(mdl[15].me), 64'd0);
        chk("mdl_56_w31", 64'(mdl[31].d), 64'h1C0);
        expect_msg();
        send_msg(1'b0);
        wait_drain();

        // 3-cycle stall at word index 5
        hs_count   = 0;
        stall_left = 3;
        rdy_mode   = 2;
        rand_msg(20);
        expect_msg();
        send_msg(1'b0);
        wait_drain();
        chk("stall_consumed", 64'(stall_left), 64'd0);
        rdy_mode = 0;

        // random backpressure over three back-to-back messages
        rdy_mode = 1;
        for (int m = 0; m < 3; m++) begin
            rand_msg($urandom_range(0, 70));
            expect_msg();
            send_msg(1'b0);
        end
        wait_drain();
        rdy_mode = 0;

        // reset while zero filling
        hs_count = 0;
        rand_msg(5);
        expect_msg();
        send_msg(1'b0);
        guard = 0;
        while (hs_count < 4 && guard < 100) begin
            @(posedge ACLK);
            #1;
            guard++;
        end
        chk("reached_zero_fill", 64'(hs_count >= 4), 64'd1);
        ARESET = 1'b1;
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        exp_q.delete();
        @(negedge ACLK);
        chk("post_rst_m_valid", 64'(m_valid), 64'd0);
        @(posedge ACLK);
        #1;
        msg.delete();
        msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
        expect_msg();
        send_msg(1'b0);
        wait_drain();

        // randomized soak
        rdy_mode = 1;
        for (int m = 0; m < 8; m++) begin
            rand_msg($urandom_range(0, 140));
            expect_msg();
            send_msg(1'b1);
        end
        wait_drain();
        rdy_mode = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
